// File: rtl/nv_nvdla_pdp_stub.sv
// PDP stub: CSB register file plus a beat-counting engine on the sdp2pdp stream.
// Completion sets a sticky status bit and pulses the done interrupt once.
module nv_nvdla_pdp_stub #(
   parameter int NUM_REGS = 8,
   parameter int DATA_W   = 128,
   parameter int CNT_W    = 32
) (
   input  logic              nvdla_core_clk,
   input  logic              nvdla_core_rst,
   input  logic              csb2pdp_req_pvld,
   output logic              csb2pdp_req_prdy,
   input  logic [62:0]       csb2pdp_req_pd,
   output logic              pdp2csb_resp_valid,
   output logic [33:0]       pdp2csb_resp_pd,
   input  logic              sdp2pdp_valid,
   output logic              sdp2pdp_ready,
   input  logic [DATA_W-1:0] sdp2pdp_pd,
   output logic [1:0]        pdp2glb_done_intr_pd
);

   localparam int IDX_W = $clog2(NUM_REGS);
   localparam int NS    = (NUM_REGS > 4) ? NUM_REGS - 4 : 1;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   logic [0:0]       state;
   logic [CNT_W-1:0] beat_total;
   logic [CNT_W-1:0] beat_count;
   logic             done_sticky;
   logic             intr_q;
   logic             resp_valid_q;
   logic [33:0]      resp_pd_q;
   logic [31:0]      scratch [NS];

   logic [IDX_W-1:0] idx;
   logic             err;
   logic [31:0]      wdat;
   logic             wr;
   logic             nposted;
   logic [3:0]       wrbe;
   logic [31:0]      mask;
   logic             acc;
   logic             wr_acc;
   logic             sel_op, sel_tot, sel_cnt, sel_sts;
   logic [31:0]      scr_rd;
   logic [31:0]      rdat;
   logic             busy;
   logic             beat;
   logic             over;
   logic [CNT_W-1:0] count_inc;
   logic             start;
   logic             finish;
   logic             clr;
   logic             unused_bits;

   assign idx     = csb2pdp_req_pd[IDX_W-1:0];
   assign err     = |csb2pdp_req_pd[11:IDX_W];
   assign wdat    = csb2pdp_req_pd[53:22];
   assign wr      = csb2pdp_req_pd[54];
   assign nposted = csb2pdp_req_pd[55];
   assign wrbe    = csb2pdp_req_pd[60:57];
   assign mask    = {{8{wrbe[3]}}, {8{wrbe[2]}}, {8{wrbe[1]}}, {8{wrbe[0]}}};

   assign unused_bits = ^{csb2pdp_req_pd[62:61], csb2pdp_req_pd[56],
                          csb2pdp_req_pd[21:12], sdp2pdp_pd};

   assign csb2pdp_req_prdy = ~nvdla_core_rst;
   assign acc              = csb2pdp_req_pvld & ~nvdla_core_rst;
   assign wr_acc           = acc & wr & ~err;

   assign sel_op  = (idx == IDX_W'(0));
   assign sel_tot = (idx == IDX_W'(1));
   assign sel_cnt = (idx == IDX_W'(2));
   assign sel_sts = (idx == IDX_W'(3));

   assign busy      = (state == BUSY);
   assign beat      = sdp2pdp_valid;
   assign over      = (beat_count >= beat_total);
   assign count_inc = beat_count + CNT_W'(1);
   assign start     = wr_acc & sel_op & wrbe[0] & wdat[0] & ~busy;
   assign clr       = wr_acc & sel_sts & wrbe[0] & wdat[0];
   // A total already reached (including zero) completes without a beat.
   assign finish    = busy & (over | (beat & (count_inc == beat_total)));

   always_comb begin
      scr_rd = '0;
      for (int i = 0; i < NS; i++) begin
         if (NUM_REGS > 4 && int'(idx) == i + 4) scr_rd = scratch[i];
      end
   end

   always_comb begin
      rdat = '0;
      unique case (1'b1)
         sel_op:  rdat = {31'd0, busy};
         sel_tot: rdat = 32'(beat_total);
         sel_cnt: rdat = 32'(beat_count);
         sel_sts: rdat = {31'd0, done_sticky};
         default: rdat = scr_rd;
      endcase
      if (err) rdat = '0;
   end

   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         state        <= IDLE;
         beat_total   <= '0;
         beat_count   <= '0;
         done_sticky  <= 1'b0;
         intr_q       <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_pd_q    <= '0;
         for (int i = 0; i < NS; i++) scratch[i] <= '0;
      end else begin
         intr_q       <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_pd_q    <= '0;
         if (acc && !wr) begin
            resp_valid_q <= 1'b1;
            resp_pd_q    <= {1'b0, err, rdat};
         end else if (acc && nposted) begin
            resp_valid_q <= 1'b1;
            resp_pd_q    <= {1'b1, err, 32'd0};
         end

         if (wr_acc && sel_tot)
            beat_total <= CNT_W'((32'(beat_total) & ~mask) | (wdat & mask));

         for (int i = 0; i < NS; i++) begin
            if (NUM_REGS > 4 && wr_acc && int'(idx) == i + 4)
               scratch[i] <= (scratch[i] & ~mask) | (wdat & mask);
         end

         if (!busy) begin
            if (start) begin
               state      <= BUSY;
               beat_count <= '0;
            end
         end else begin
            if (beat && !over) beat_count <= count_inc;
            if (finish) begin
               state  <= IDLE;
               intr_q <= 1'b1;
            end
         end

         // Set wins over a coincident W1C.
         if (finish)   done_sticky <= 1'b1;
         else if (clr) done_sticky <= 1'b0;
      end
   end

   assign sdp2pdp_ready        = 1'b1;
   assign pdp2csb_resp_valid   = resp_valid_q & ~nvdla_core_rst;
   assign pdp2csb_resp_pd      = nvdla_core_rst ? 34'd0 : resp_pd_q;
   assign pdp2glb_done_intr_pd = {1'b0, intr_q & ~nvdla_core_rst};

endmodule

// File: doc/nv_nvdla_pdp_stub.md
NV_NVDLA_PDP_STUB -- requirements
Module: nv_nvdla_pdp_stub

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NUM_REGS, 8, CSB register count, power of 2, 4..64.
- DATA_W, 128, sdp2pdp payload width.
- CNT_W, 32, beat counter width, 1..32.
REQ-002 Ports (name, direction, width, meaning); one clock, reset synchronous active-high:
- nvdla_core_clk  in  1  sole clock.
- nvdla_core_rst  in  1  synchronous active-high reset.
- csb2pdp_req_pvld  in  1  CSB request valid.
- csb2pdp_req_prdy  out  1  CSB request ready.
- csb2pdp_req_pd  in  63  [21:0] addr, [53:22] wdat, [54] write, [55] nposted, [60:57] wrbe.
- pdp2csb_resp_valid  out  1  response valid, single-cycle.
- pdp2csb_resp_pd  out  34  [31:0] rdat, [32] error, [33] type (0 read, 1 write).
- sdp2pdp_valid  in  1  stream beat valid.
- sdp2pdp_ready  out  1  stream beat ready.
- sdp2pdp_pd  in  DATA_W  beat payload, discarded.
- pdp2glb_done_intr_pd  out  2  [0] done pulse, [1] tied 0.

Function
REQ-003 csb2pdp_req_prdy SHALL be 1 whenever not in reset; request accepted when pvld is high.
REQ-004 Index SHALL be addr[log2(NUM_REGS)-1:0]; nonzero addr[11:log2(NUM_REGS)] SHALL set error=1, read data 0, write ignored; addr[21:12] ignored.
REQ-005 Register map: 0 OP_ENABLE (bit0 R/W1S, reads busy); 1 BEAT_TOTAL (RW, CNT_W bits); 2 BEAT_COUNT (RO); 3 STATUS (bit0 done_sticky, W1C); 4..NUM_REGS-1 scratch RW 32-bit.
REQ-006 RW writes SHALL honour wrbe per byte; W1S/W1C bits SHALL act only when wrbe[0]=1; writes to RO registers ignored, error=0.
REQ-007 Read response SHALL assert exactly 1 cycle after acceptance with pd={1'b0,err,rdat}; unused upper bits read 0.
REQ-008 Non-posted write SHALL respond 1 cycle after acceptance with pd={1'b1,err,32'd0}; posted write SHALL produce no response.
REQ-009 pdp2csb_resp_pd SHALL be 0 whenever resp_valid is 0.
REQ-010 Engine states: IDLE, BUSY. IDLE->BUSY on OP_ENABLE write of 1; BEAT_COUNT cleared to 0 on that same edge.
REQ-011 OP_ENABLE write of 1 while BUSY SHALL be ignored (no count clear).
REQ-012 sdp2pdp_ready SHALL be 1 in both states; beats in IDLE are discarded and not counted.
REQ-013 In BUSY, each valid beat SHALL increment BEAT_COUNT by 1; when the incremented value equals BEAT_TOTAL the block SHALL go to IDLE, set done_sticky, and pulse intr_pd[0] for exactly 1 cycle on the following cycle.
REQ-014 BUSY entered with BEAT_TOTAL=0 SHALL complete on the next cycle with no beat required (count stays 0).
REQ-015 BEAT_TOTAL writes while BUSY SHALL take effect immediately; if the new total is <= the current count, completion SHALL occur on the next cycle.
REQ-016 A CSB read in the same cycle as a beat increment SHALL return the pre-increment value; a STATUS W1C coinciding with done set SHALL leave done_sticky=1.
REQ-017 The counter SHALL never wrap, since it stops at BEAT_TOTAL.

Reset
REQ-018 While rst=1: prdy=0, resp_valid=0, resp_pd=0, intr_pd=0, state IDLE, all registers 0; a request presented during reset SHALL be dropped with no response.
REQ-019 Reset asserted mid-BUSY SHALL abort without an interrupt; the first cycle after deassertion behaves as a fresh IDLE.

Verification
REQ-020 Write 0xA5A5A5A5 nposted to scratch reg 4 with wrbe=4'b0011, then read it -> write resp {1,0,0}; read resp rdat=0x0000A5A5, err=0.
REQ-021 Read addr 0x010 with NUM_REGS=8 -> 1 cycle later resp_pd={0,1,32'd0}.
REQ-022 BEAT_TOTAL=3, OP_ENABLE=1, 5 beats with gaps -> BEAT_COUNT reaches 3, one intr_pd[0] pulse, STATUS=1, beats 4-5 not counted.
REQ-023 BEAT_TOTAL=0, OP_ENABLE=1 -> intr_pd[0] pulses 2 cycles after the write, with no beats sent.
REQ-024 Reset asserted after 2 of 4 beats -> no interrupt; after reset all register reads return 0.
REQ-025 BEAT_COUNT read coinciding with the 2nd beat -> returns 1; next read returns 2.
